// File: rtl/pq_arbiter.sv
// Round-robin arbiter/sequencer sharing one priority-queue device among NREQ requesters.
// Optional per-requester/reject statistics counters are built when PQ_ARB_STATS_EN is defined.

package pq_arbiter_pkg;
   localparam int KEY_W = 8;
   localparam int VAL_W = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   localparam int  KV_W     = $bits(kv_t);
   localparam kv_t KV_EMPTY = '{key: '1, val: '0};

   typedef enum logic [1:0] {
      OP_RSVD = 2'b00,
      OP_ENQ  = 2'b01,
      OP_DEQ  = 2'b10,
      OP_REPL = 2'b11
   } op_e;
endpackage

module pq_arbiter
   import pq_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int IDX_W = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [2*NREQ-1:0]    req_op,
   input  logic [NREQ*KV_W-1:0] req_kv,
   output logic [NREQ-1:0]      resp_valid,
   output logic                 resp_err,
   output kv_t                  resp_kv,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 pq_enq,
   output logic                 pq_deq,
   output kv_t                  pq_kvi,
   input  kv_t                  pq_kvo,
   input  logic                 pq_full,
   input  logic                 pq_empty,
   input  logic                 pq_busy
`ifdef PQ_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]   stat_ops,
   output logic [15:0]          stat_rej
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state, state_d;
   logic [IDX_W-1:0] rr_ptr, rr_d;
   logic [IDX_W-1:0] grant_d;
   logic             enq_d, deq_d;
   kv_t              kvi_d;
   logic [NREQ-1:0]  valid_d;
   logic             err_d;
   kv_t              rkv_d;

   logic [1:0]       op_a [NREQ];
   kv_t              kv_a [NREQ];
   logic [NREQ-1:0]  eligible;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] cand;
   logic [1:0]       pick_op;
   kv_t              pick_kv;
   logic             pick_legal;
   logic [NREQ-1:0]  pick_1h;
   logic [NREQ-1:0]  grant_1h;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = req_op[2*i +: 2];
         kv_a[i] = req_kv[i*KV_W +: KV_W];
      end
   end

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment,
      // otherwise a path that skips it would infer a latch.
      eligible = req & ~resp_valid;
      found    = 1'b0;
      pick     = '0;
      cand     = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = IDX_W'((int'(rr_ptr) + i) % NREQ);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      pick_op  = op_a[pick];
      pick_kv  = kv_a[pick];
      pick_1h  = NREQ'(1) << pick;
      grant_1h = NREQ'(1) << grant_idx;
      unique case (pick_op)
         OP_ENQ:          pick_legal = !pq_full;
         OP_DEQ, OP_REPL: pick_legal = !pq_empty;
         default:         pick_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state;
      rr_d    = rr_ptr;
      grant_d = grant_idx;
      enq_d   = 1'b0;
      deq_d   = 1'b0;
      kvi_d   = KV_EMPTY;
      valid_d = '0;
      err_d   = 1'b0;
      rkv_d   = resp_kv;
      unique case (state)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               rr_d    = pick;
               if (pick_legal) begin
                  state_d = ISSUE;
                  enq_d   = pick_op[0];
                  deq_d   = pick_op[1];
                  kvi_d   = pick_kv;
               end else begin
                  // Rejects carry no dequeued item, so the response shows KV_EMPTY.
                  state_d = RESP;
                  valid_d = pick_1h;
                  err_d   = 1'b1;
                  rkv_d   = KV_EMPTY;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
            rkv_d   = pq_deq ? pq_kvo : KV_EMPTY;
         end
         WAIT: begin
            if (!pq_busy) begin
               state_d = RESP;
               valid_d = grant_1h;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= IDX_W'(NREQ - 1);
         grant_idx  <= '0;
         pq_enq     <= 1'b0;
         pq_deq     <= 1'b0;
         pq_kvi     <= KV_EMPTY;
         resp_valid <= '0;
         resp_err   <= 1'b0;
         resp_kv    <= KV_EMPTY;
      end else begin
         state      <= state_d;
         rr_ptr     <= rr_d;
         grant_idx  <= grant_d;
         pq_enq     <= enq_d;
         pq_deq     <= deq_d;
         pq_kvi     <= kvi_d;
         resp_valid <= valid_d;
         resp_err   <= err_d;
         resp_kv    <= rkv_d;
      end
   end

`ifdef PQ_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_ops <= '0;
         stat_rej <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (state == ISSUE && grant_idx == IDX_W'(i) && stat_ops[i*16 +: 16] != 16'hFFFF)
               stat_ops[i*16 +: 16] <= stat_ops[i*16 +: 16] + 16'd1;
         end
         if (state == RESP && resp_err && stat_rej != 16'hFFFF)
            stat_rej <= stat_rej + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pq_arbiter.sv
// Scoreboard bench for pq_arbiter: a behavioural sorted queue acts as the device,
// directed operations push expected responses/strobes, monitors pop and compare.

module tb_pq_arbiter;
   import pq_arbiter_pkg::*;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;
   localparam int CAP   = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req = '0;
   logic [1:0]           op_a [NREQ];
   kv_t                  kv_a [NREQ];
   logic [2*NREQ-1:0]    req_op;
   logic [NREQ*KV_W-1:0] req_kv;
   logic [NREQ-1:0]      resp_valid;
   logic                 resp_err;
   kv_t                  resp_kv;
   logic [IDX_W-1:0]     grant_idx;
   logic                 pq_enq, pq_deq;
   kv_t                  pq_kvi;
   kv_t                  pq_kvo   = KV_EMPTY;
   logic                 pq_full  = 1'b0;
   logic                 pq_empty = 1'b1;
   logic                 pq_busy;
`ifdef PQ_ARB_STATS_EN
   logic [NREQ*16-1:0]   stat_ops;
   logic [15:0]          stat_rej;
`endif

   int  cyc      = 0;
   int  n_checks = 0;
   int  n_fail   = 0;
   int  busy_cnt = 0;
   int  busy_len = 0;
   kv_t mem[$];

   typedef struct {
      logic [NREQ-1:0]  vec;
      logic [IDX_W-1:0] idx;
      logic             err;
      kv_t              kv;
      int               due;
   } resp_exp_t;

   typedef struct {
      logic enq;
      logic deq;
      kv_t  kv;
      int   due;
   } stb_exp_t;

   resp_exp_t resp_q[$];
   stb_exp_t  stb_q[$];

   pq_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_op     (req_op),
      .req_kv     (req_kv),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_kv    (resp_kv),
      .grant_idx  (grant_idx),
      .pq_enq     (pq_enq),
      .pq_deq     (pq_deq),
      .pq_kvi     (pq_kvi),
      .pq_kvo     (pq_kvo),
      .pq_full    (pq_full),
      .pq_empty   (pq_empty),
      .pq_busy    (pq_busy)
`ifdef PQ_ARB_STATS_EN
      ,
      .stat_ops   (stat_ops),
      .stat_rej   (stat_rej)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign pq_busy = (busy_cnt != 0);

   always_comb begin
      req_op = '0;
      req_kv = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_op[2*i +: 2]      = op_a[i];
         req_kv[i*KV_W +: KV_W] = kv_a[i];
      end
   end

   // Device model: min-key-first queue, updated just after the edge that saw a strobe.
   always @(posedge clk) begin : pq_model
      logic e, d;
      kv_t  k;
      int   pos;
      e = pq_enq;
      d = pq_deq;
      k = pq_kvi;
      #1;
      if (e || d) begin
         if (d && mem.size() > 0) void'(mem.pop_front());
         if (e) begin
            pos = mem.size();
            for (int i = 0; i < mem.size(); i++) begin
               if (mem[i].key > k.key) begin
                  pos = i;
                  break;
               end
            end
            mem.insert(pos, k);
         end
         busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
         busy_cnt = busy_cnt - 1;
      end
      pq_kvo   = (mem.size() > 0) ? mem[0] : KV_EMPTY;
      pq_empty = (mem.size() == 0);
      pq_full  = (mem.size() >= CAP);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic kv_t mk(input logic [7:0] k, input logic [7:0] v);
      return '{key: k, val: v};
   endfunction

   always @(negedge clk) begin : mon_resp
      resp_exp_t re;
      if (!rst && resp_valid != '0) begin
         if (resp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_unexpected: got resp_valid=%b, none was due (cycle %0d)", resp_valid, cyc);
         end else begin
            re = resp_q.pop_front();
            check("resp_valid", resp_valid, re.vec);
            check("resp_grant_idx", grant_idx, re.idx);
            check("resp_err", resp_err, re.err);
            check("resp_kv", resp_kv, re.kv);
            check("resp_cycle", cyc, re.due);
         end
      end
   end

   always @(negedge clk) begin : mon_stb
      stb_exp_t se;
      if (!rst && (pq_enq || pq_deq)) begin
         if (stb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_unexpected: got enq=%b deq=%b, none was due (cycle %0d)", pq_enq, pq_deq, cyc);
         end else begin
            se = stb_q.pop_front();
            check("pq_enq", pq_enq, se.enq);
            check("pq_deq", pq_deq, se.deq);
            check("pq_kvi", pq_kvi, se.kv);
            check("strobe_cycle", cyc, se.due);
         end
      end
   end

   task automatic expect_resp(input int idx, input logic err, input kv_t kv, input int due);
      resp_exp_t r;
      r.vec = NREQ'(1) << idx;
      r.idx = IDX_W'(idx);
      r.err = err;
      r.kv  = kv;
      r.due = due;
      resp_q.push_back(r);
   endtask

   task automatic expect_stb(input logic enq, input logic deq, input kv_t kv, input int due);
      stb_exp_t s;
      s.enq = enq;
      s.deq = deq;
      s.kv  = kv;
      s.due = due;
      stb_q.push_back(s);
   endtask

   // Raise a request, hold it until its response, drop it after the RESP edge.
   task automatic hold_req(input int idx, input logic [1:0] op, input kv_t kv);
      op_a[idx] = op;
      kv_a[idx] = kv;
      req[idx]  = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (resp_valid[idx]) break;
      end
      if (!resp_valid[idx]) begin
         n_checks++;
         n_fail++;
         $display("FAIL resp_timeout: requester %0d got no response within 40 cycles", idx);
      end
      @(posedge clk);
      #1;
      req[idx] = 1'b0;
   endtask

   task automatic op1(input int idx, input logic [1:0] op, input kv_t kv,
                      input logic err, input kv_t exp_kv, input int lat);
      int c;
      c = cyc;
      expect_resp(idx, err, exp_kv, c + lat);
      if (!err) expect_stb(op[0], op[1], kv, c + 1);
      hold_req(idx, op, kv);
   endtask

   initial begin
      int c;
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = OP_RSVD;
         kv_a[i] = KV_EMPTY;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_resp_valid", resp_valid, 0);
      check("reset_resp_err", resp_err, 0);
      check("reset_resp_kv", resp_kv, KV_EMPTY);
      check("reset_grant_idx", grant_idx, 0);
      check("reset_pq_enq", pq_enq, 0);
      check("reset_pq_deq", pq_deq, 0);
      check("reset_pq_kvi", pq_kvi, KV_EMPTY);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Rejects: DEQ on empty queue, reserved opcode.
      op1(0, OP_DEQ,  mk(8'h00, 8'h00), 1'b1, KV_EMPTY, 1);
      op1(1, OP_RSVD, mk(8'h01, 8'h01), 1'b1, KV_EMPTY, 1);
      // Single ENQ, then dequeue it.
      op1(2, OP_ENQ,  mk(8'd5, 8'h55), 1'b0, KV_EMPTY, 3);
      op1(3, OP_DEQ,  mk(8'h30, 8'h30), 1'b0, mk(8'd5, 8'h55), 3);
      // Head ordering: 7 then 3 enqueued, DEQ returns 3 then 7 (second with 2 busy cycles).
      op1(0, OP_ENQ,  mk(8'd7, 8'h77), 1'b0, KV_EMPTY, 3);
      op1(1, OP_ENQ,  mk(8'd3, 8'h33), 1'b0, KV_EMPTY, 3);
      op1(2, OP_DEQ,  mk(8'h20, 8'h20), 1'b0, mk(8'd3, 8'h33), 3);
      busy_len = 2;
      op1(3, OP_DEQ,  mk(8'h31, 8'h31), 1'b0, mk(8'd7, 8'h77), 5);
      busy_len = 0;

      // Round-robin with everyone requesting; requester 0's second ENQ hits a full queue.
      c = cyc;
      expect_stb(1'b1, 1'b0, mk(8'd10, 8'hA0), c + 1);
      expect_resp(0, 1'b0, KV_EMPTY, c + 3);
      expect_stb(1'b1, 1'b0, mk(8'd11, 8'hA1), c + 5);
      expect_resp(1, 1'b0, KV_EMPTY, c + 7);
      expect_stb(1'b1, 1'b0, mk(8'd12, 8'hA2), c + 9);
      expect_resp(2, 1'b0, KV_EMPTY, c + 11);
      expect_stb(1'b1, 1'b0, mk(8'd13, 8'hA3), c + 13);
      expect_resp(3, 1'b0, KV_EMPTY, c + 15);
      expect_resp(0, 1'b1, KV_EMPTY, c + 17);
      fork
         begin
            hold_req(0, OP_ENQ, mk(8'd10, 8'hA0));
            hold_req(0, OP_ENQ, mk(8'd14, 8'hA4));
         end
         hold_req(1, OP_ENQ, mk(8'd11, 8'hA1));
         hold_req(2, OP_ENQ, mk(8'd12, 8'hA2));
         hold_req(3, OP_ENQ, mk(8'd13, 8'hA3));
      join

      // Full queue: ENQ rejected, REPLACE accepted and returns the old head.
      op1(1, OP_ENQ,  mk(8'd20, 8'hB0), 1'b1, KV_EMPTY, 1);
      op1(2, OP_REPL, mk(8'd1, 8'h11), 1'b0, mk(8'd10, 8'hA0), 3);
      op1(3, OP_DEQ,  mk(8'h32, 8'h32), 1'b0, mk(8'd1, 8'h11), 3);

      // Asynchronous reset while waiting on a busy queue.
      busy_len = 3;
      c = cyc;
      expect_stb(1'b0, 1'b1, mk(8'h99, 8'h99), c + 1);
      op_a[1] = OP_DEQ;
      kv_a[1] = mk(8'h99, 8'h99);
      req[1]  = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("wait_resp_kv_captured", resp_kv, mk(8'd11, 8'hA1));
      check("wait_grant_idx", grant_idx, 1);
`ifdef PQ_ARB_STATS_EN
      check("stat_ops_0", stat_ops[15:0], 2);
      check("stat_ops_1", stat_ops[31:16], 3);
      check("stat_ops_2", stat_ops[47:32], 4);
      check("stat_ops_3", stat_ops[63:48], 4);
      check("stat_rej", stat_rej, 4);
`endif
      rst    = 1'b1;
      req[1] = 1'b0;
      #1;
      check("async_rst_resp_valid", resp_valid, 0);
      check("async_rst_resp_err", resp_err, 0);
      check("async_rst_resp_kv", resp_kv, KV_EMPTY);
      check("async_rst_grant_idx", grant_idx, 0);
      check("async_rst_pq_enq", pq_enq, 0);
      check("async_rst_pq_deq", pq_deq, 0);
      check("async_rst_pq_kvi", pq_kvi, KV_EMPTY);
`ifdef PQ_ARB_STATS_EN
      check("async_rst_stat_ops", stat_ops, 0);
      check("async_rst_stat_rej", stat_rej, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      busy_len = 0;

      // After reset requester 0 must win even though 3 also requests.
      c = cyc;
      expect_stb(1'b0, 1'b1, mk(8'h40, 8'h40), c + 1);
      expect_resp(0, 1'b0, mk(8'd12, 8'hA2), c + 3);
      expect_stb(1'b0, 1'b1, mk(8'h43, 8'h43), c + 5);
      expect_resp(3, 1'b0, mk(8'd13, 8'hA3), c + 7);
      fork
         hold_req(0, OP_DEQ, mk(8'h40, 8'h40));
         hold_req(3, OP_DEQ, mk(8'h43, 8'h43));
      join

      repeat (3) @(posedge clk);
      #1;
      check("resp_queue_drained", resp_q.size(), 0);
      check("strobe_queue_drained", stb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
